led_pattern_arbiter: RTL and testbench
======================================

LED_PATTERN_ARBITER -- requirements
Module: led_pattern_arbiter

Interface
REQ-001 Parameter NREQ, default 2, number of requesters (range 2..4).
REQ-002 Parameter DIV_W, default 21, prescaler width; one pattern bit lasts 2^DIV_W clk cycles (about 131 ms at 16 MHz).
REQ-003 clk  input  1  system clock; all logic SHALL be clocked on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 req  input  NREQ  per-requester level request; bit i is held high while requester i wants the LED.
REQ-006 pattern  input  32*NREQ  requester i pattern in bits [32i+31:32i]; bit 0 is played first.
REQ-007 plen  input  5*NREQ  requester i pattern length minus one, in bits [5i+4:5i] (0..31).
REQ-008 grant  output  NREQ  one-hot or zero; bit i high while requester i owns the LED.
REQ-009 done  output  NREQ  one-cycle pulse on bit i when requester i's pattern completes normally.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 led  output  1  LED drive, active-high.
REQ-012 usbpu  output  1  SHALL be constant 0 (USB pull-up disabled).

Function
REQ-013 The block SHALL implement the states IDLE, PLAY and GAP.
REQ-014 IDLE: led=0 and grant=0; when any req bit is high, the arbiter SHALL select one winner by round-robin.
REQ-015 Round-robin search SHALL start at index (last_winner+1) mod NREQ; last_winner resets to NREQ-1, so index 0 wins first after reset.
REQ-016 On selection, the arbiter SHALL do all of the following on the same edge:
- latch the winner's pattern and plen;
- set grant to the winner one-hot;
- clear the bit index and prescaler;
- enter PLAY.
REQ-017 grant SHALL be high from the first cycle of PLAY.
REQ-018 PLAY: led SHALL equal latched_pattern[bit_idx] and SHALL be registered, with no combinational path from pattern to led.
REQ-019 PLAY: the prescaler SHALL count 0..2^DIV_W-1 and wrap to 0; at terminal count:
- if bit_idx < latched plen, increment bit_idx;
- if bit_idx equals latched plen, pulse done for the winner for one cycle, clear grant and enter GAP on that edge.
REQ-020 Changes to pattern or plen inputs during PLAY SHALL have no effect; only the values latched at selection are used.
REQ-021 Abort: if the granted requester's req is low in any PLAY cycle, the block SHALL clear grant, force led=0 and enter GAP on the next edge, with no done pulse.
REQ-022 Requests from other requesters during PLAY or GAP SHALL be ignored (non-preemptive) and remain pending.
REQ-023 GAP: led=0 and grant=0 for exactly 2^DIV_W cycles (prescaler restarts at 0), then the block SHALL return to IDLE.
REQ-024 A new selection SHALL occur on the first IDLE cycle, so back-to-back owners are separated by exactly one GAP period plus one IDLE cycle.
REQ-025 A requester still holding req after done SHALL be re-eligible, but SHALL lose round-robin to any other pending requester.
REQ-026 plen=0 SHALL play exactly one bit period.
REQ-027 bit_idx SHALL never exceed 31 and SHALL not wrap.
REQ-028 At most one done bit SHALL be high in any cycle, and done SHALL never coincide with a nonzero grant for a different requester.
REQ-029 busy SHALL equal (state != IDLE).

Reset
REQ-030 Asserting reset low SHALL, asynchronously and mid-operation, force all of the following:
- state IDLE;
- grant=0, done=0, busy=0, led=0;
- bit_idx and prescaler to 0;
- last_winner to NREQ-1.
REQ-031 After reset deasserts, the first selection SHALL occur on the first rising edge with req nonzero.

Verification (DIV_W=2, so one bit = 4 cycles; NREQ=2)
REQ-032 The bench SHALL cover a single playback:
- stimulus: req=01, pattern0=0x0000_0005, plen0=2;
- response: grant=01 next edge; led = 1,0,1 for 4 cycles each; done[0] pulses in the 12th PLAY cycle; led=0 for 4 GAP cycles; busy drops afterward.
REQ-033 The bench SHALL cover contention:
- stimulus: req=11 held, both plen=0;
- response: owner order 0,1,0,1; each grant lasts 4 cycles; consecutive grants are 5 cycles apart.
REQ-034 The bench SHALL cover abort:
- stimulus: req0 drops in cycle 6 of a plen0=31 play;
- response: grant0 clears next edge; no done; led=0; GAP of 4 cycles, then IDLE.
REQ-035 The bench SHALL cover mid-play reset:
- stimulus: reset low during PLAY at bit 3;
- response: all outputs 0 immediately, without waiting for a clock edge;
- after release with req=10, requester 1 is granted first.
REQ-036 The bench SHALL cover input change during play:
- stimulus: pattern0 changed during PLAY;
- response: led continues the latched pattern; plen0=31 plays 32 bits, with done at cycle 128.

Source files
------------

// File: rtl/led_pattern_arbiter.sv
// Round-robin LED pattern arbiter: one requester at a time plays its latched
// bit pattern on the LED, then the LED rests for one bit period before re-arbitration.
module led_pattern_arbiter #(
  parameter int NREQ  = 2,
  parameter int DIV_W = 21
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [32*NREQ-1:0]   pattern,
  input  logic [5*NREQ-1:0]    plen,
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      done,
  output logic                 busy,
  output logic                 led,
  output logic                 usbpu
);

  localparam int LW_W = (NREQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [NREQ-1:0]  grant_nxt;
  logic             led_nxt;
  logic [4:0]       bit_idx, bit_nxt, bit_inc;
  logic [DIV_W-1:0] presc, presc_nxt;
  logic [LW_W-1:0]  last_winner, last_winner_nxt;
  logic [31:0]      pat_lat;
  logic [4:0]       plen_lat;
  logic [31:0]      pat_arr  [NREQ];
  logic [4:0]       plen_arr [NREQ];
  logic [LW_W-1:0]  cand, sel;
  logic             found;
  int               rr_idx;
  logic             load;
  logic             presc_tc;
  logic             own_req;

  genvar g;
  generate
    for (g = 0; g < NREQ; g++) begin : g_split
      assign pat_arr[g]  = pattern[32*g +: 32];
      assign plen_arr[g] = plen[5*g +: 5];
    end
  endgenerate

  // Search starts just after the previous owner, so a re-requesting owner comes last.
  always_comb begin
    sel    = last_winner;
    found  = 1'b0;
    cand   = '0;
    rr_idx = 0;
    for (int k = 1; k <= NREQ; k++) begin
      rr_idx = (int'(last_winner) + k) % NREQ;
      cand   = LW_W'(rr_idx);
      if (!found && req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  assign presc_tc = &presc;
  assign own_req  = |(req & grant);
  assign bit_inc  = bit_idx + 5'd1;

  always_comb begin
    state_nxt       = state;
    grant_nxt       = grant;
    led_nxt         = led;
    bit_nxt         = bit_idx;
    presc_nxt       = presc;
    last_winner_nxt = last_winner;
    load            = 1'b0;
    done            = '0;
    case (state)
      IDLE: begin
        grant_nxt = '0;
        led_nxt   = 1'b0;
        if (found) begin
          last_winner_nxt = sel;
          grant_nxt       = NREQ'(1) << sel;
          led_nxt         = pat_arr[sel][0];
          bit_nxt         = '0;
          presc_nxt       = '0;
          load            = 1'b1;
          state_nxt       = PLAY;
        end
      end
      PLAY: begin
        presc_nxt = presc + 1'b1;
        if (!own_req) begin
          grant_nxt = '0;
          led_nxt   = 1'b0;
          presc_nxt = '0;
          state_nxt = GAP;
        end else if (presc_tc) begin
          if (bit_idx == plen_lat) begin
            done      = grant;
            grant_nxt = '0;
            led_nxt   = 1'b0;
            presc_nxt = '0;
            state_nxt = GAP;
          end else begin
            bit_nxt = bit_inc;
            led_nxt = pat_lat[bit_inc];
          end
        end
      end
      GAP: begin
        grant_nxt = '0;
        led_nxt   = 1'b0;
        presc_nxt = presc + 1'b1;
        if (presc_tc) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
        led_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      grant       <= '0;
      led         <= 1'b0;
      bit_idx     <= '0;
      presc       <= '0;
      last_winner <= LW_W'(NREQ - 1);
    end else begin
      state       <= state_nxt;
      grant       <= grant_nxt;
      led         <= led_nxt;
      bit_idx     <= bit_nxt;
      presc       <= presc_nxt;
      last_winner <= last_winner_nxt;
    end
  end

  // Pattern snapshot is pure data; it is only meaningful after a selection.
  always_ff @(posedge clk) begin
    if (load) begin
      pat_lat  <= pat_arr[sel];
      plen_lat <= plen_arr[sel];
    end
  end

  assign busy  = (state != IDLE);
  assign usbpu = 1'b0;

endmodule

// File: tb/tb_led_pattern_arbiter.sv
// Bench for led_pattern_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a cycle-count based reference model.
module tb_led_pattern_arbiter;

  localparam int N  = 2;
  localparam int DW = 2;
  localparam int BP = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [32*N-1:0] pattern;
  logic [5*N-1:0]  plen;
  logic [N-1:0]    grant;
  logic [N-1:0]    done;
  logic            busy;
  logic            led;
  logic            usbpu;

  int total = 0;
  int bad   = 0;

  led_pattern_arbiter #(.NREQ(N), .DIV_W(DW)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .pattern (pattern),
    .plen    (plen),
    .grant   (grant),
    .done    (done),
    .busy    (busy),
    .led     (led),
    .usbpu   (usbpu)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 idle, 1 playing (m_t cycles elapsed), 2 resting (m_g cycles elapsed)
  int          m_mode, m_own, m_lw, m_t, m_g, m_plen;
  logic [31:0] m_pat;

  logic [N-1:0] o_grant, o_done;
  logic         o_busy, o_led;

  int   gs, dc, be, pc, ns, ne, dn, gap, lg, ia;
  logic dr;
  logic [N-1:0] prev;
  logic lv [32];
  int   st [8];
  int   en [8];
  int   ow [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_mode = 0;
    m_lw   = N - 1;
    m_own  = 0;
    m_t    = 0;
    m_g    = 0;
  endfunction

  task automatic model_edge();
    logic [63:0] sh;
    logic [9:0]  pl;
    int          pick;
    pick = -1;
    if (!reset) begin
      model_reset();
    end else begin
      case (m_mode)
        0: begin
          for (int k = 1; k <= N; k++) begin
            int i;
            i = (m_lw + k) % N;
            if (pick < 0 && ((req >> i) & 1) != 0) pick = i;
          end
          if (pick >= 0) begin
            sh     = pattern >> (32 * pick);
            m_pat  = sh[31:0];
            pl     = plen >> (5 * pick);
            m_plen = int'(pl[4:0]);
            m_own  = pick;
            m_lw   = pick;
            m_t    = 0;
            m_mode = 1;
          end
        end
        1: begin
          if (((req >> m_own) & 1) == 0) begin
            m_mode = 2;
            m_g    = 0;
          end else if (m_t == BP * (m_plen + 1) - 1) begin
            m_mode = 2;
            m_g    = 0;
          end else begin
            m_t++;
          end
        end
        default: begin
          if (m_g == BP - 1) m_mode = 0;
          else m_g++;
        end
      endcase
    end
  endtask

  task automatic step();
    logic [31:0] e_grant, e_done, e_led, e_busy;
    @(negedge clk);
    o_grant = grant;
    o_done  = done;
    o_busy  = busy;
    o_led   = led;
    e_grant = (m_mode == 1) ? (32'd1 << m_own) : 32'd0;
    e_led   = (m_mode == 1) ? ((m_pat >> (m_t / BP)) & 32'd1) : 32'd0;
    e_done  = (m_mode == 1 && ((req >> m_own) & 1) != 0 && m_t == BP * (m_plen + 1) - 1)
              ? (32'd1 << m_own) : 32'd0;
    e_busy  = (m_mode != 0) ? 32'd1 : 32'd0;
    chk("grant", 32'(o_grant), e_grant);
    chk("done",  32'(o_done),  e_done);
    chk("busy",  32'(o_busy),  e_busy);
    chk("led",   32'(o_led),   e_led);
    chk("usbpu", 32'(usbpu),   32'd0);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    model_reset();
    req = '0;
    step();
    reset = 1'b1;
  endtask

  initial begin
    reset   = 1'b0;
    req     = '0;
    pattern = '0;
    plen    = '0;
    model_reset();
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    step();
    step();
    reset = 1'b1;
    step();

    // Single playback of 1,0,1
    pattern = 64'h0000_0000_0000_0005;
    plen    = {5'd0, 5'd2};
    req     = 2'b01;
    gs = -1; dc = -1; be = -1; pc = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (o_grant != 0) begin
        if (gs < 0) gs = c;
        if (pc < 32) lv[pc] = o_led;
        pc++;
      end
      if (o_done != 0) dc = c;
      if (dc >= 0 && be < 0 && !o_busy) be = c;
      if (dc >= 0) req = '0;
    end
    chk("p1_grant_start", gs, 1);
    chk("p1_done_cycle", dc - gs, 11);
    chk("p1_busy_drop", be - dc, 5);
    chk("p1_play_len", pc, 12);
    chk("p1_led_bit0", 32'(lv[0]), 1);
    chk("p1_led_bit1", 32'(lv[4]), 0);
    chk("p1_led_bit2", 32'(lv[8]), 1);

    // Contention with both requesters held
    pulse_reset();
    pattern = {$urandom(), $urandom()};
    plen    = '0;
    req     = 2'b11;
    ns = 0; ne = 0; prev = '0;
    for (int k = 0; k < 8; k++) begin
      st[k] = -100; en[k] = -100; ow[k] = -1;
    end
    for (int c = 0; c < 40; c++) begin
      step();
      if (prev == 0 && o_grant != 0 && ns < 8) begin
        st[ns] = c;
        ow[ns] = (o_grant == 2'b10) ? 1 : 0;
        ns++;
      end
      if (prev != 0 && o_grant == 0 && ne < 8) begin
        en[ne] = c;
        ne++;
      end
      prev = o_grant;
    end
    for (int k = 0; k < 4; k++) begin
      chk("ct_owner", ow[k], k % 2);
      chk("ct_grant_len", en[k] - st[k], 4);
      if (k < 3) chk("ct_spacing", st[k+1] - en[k], 5);
    end

    // Abort in the sixth play cycle
    pulse_reset();
    pattern = {$urandom(), $urandom()};
    plen    = {5'd0, 5'd31};
    req     = 2'b01;
    pc = 0; dr = 1'b0; lg = -1; gap = 0; dn = 0; ia = -1;
    for (int c = 0; c < 40; c++) begin
      step();
      if (o_grant != 0) begin
        pc++;
        lg = c;
      end
      if (o_done != 0) dn++;
      if (dr && o_grant == 0 && o_busy) gap++;
      if (dr && !o_busy && ia < 0 && lg >= 0) ia = c;
      if (pc == 5 && !dr) begin
        req = '0;
        dr  = 1'b1;
      end
    end
    chk("ab_play_cycles", pc, 6);
    chk("ab_no_done", dn, 0);
    chk("ab_gap_len", gap, 4);
    chk("ab_idle_after", ia - lg, 5);

    // Asynchronous reset in the middle of bit 3
    pulse_reset();
    pattern = {32'h0, 32'hFFFF_FFFF};
    plen    = {5'd0, 5'd31};
    req     = 2'b01;
    pc = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (o_grant != 0) pc++;
      if (pc == 13) break;
    end
    chk("mr_pre_grant", 32'(grant), 32'd1);
    chk("mr_pre_led", 32'(led), 32'd1);
    reset = 1'b0;
    model_reset();
    #1;
    chk("mr_grant", 32'(grant), 32'd0);
    chk("mr_led", 32'(led), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_done", 32'(done), 32'd0);
    req = 2'b10;
    step();
    step();
    reset = 1'b1;
    step();
    step();
    chk("mr_first_owner", 32'(o_grant), 32'd2);

    // Inputs change while playing a 32-bit pattern
    pulse_reset();
    pattern = {$urandom(), $urandom()};
    plen    = {5'd3, 5'd31};
    req     = 2'b01;
    pc = 0; dc = -1;
    for (int c = 0; c < 160; c++) begin
      step();
      if (o_grant != 0) pc++;
      if (o_done[0] && dc < 0) dc = pc;
      if (dc >= 0) req = '0;
      if (pc >= 2 && dc < 0) begin
        pattern[31:0] = $urandom();
        plen[4:0]     = 5'($urandom_range(0, 31));
      end
    end
    chk("ic_done_cycle", dc, 128);
    chk("ic_play_len", pc, 128);

    // Randomized traffic
    pulse_reset();
    req = 2'b11;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) req = req ^ N'(1 << $urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        pattern = {$urandom(), $urandom()};
        plen    = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      end
      if ($urandom_range(0, 599) == 0) begin
        reset = 1'b0;
        model_reset();
        #1;
        chk("rnd_async_grant", 32'(grant), 32'd0);
        chk("rnd_async_busy", 32'(busy), 32'd0);
        step();
        reset = 1'b1;
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
